// File: rtl/signal_pkg.sv
// rtl/signal_pkg.sv - shared encodings for the traffic-signal lamp interface and its monitor
package signal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_A_RUN = 2'd1,
        ST_B_RUN = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_DARK     = 3'd2;
    localparam logic [2:0] FC_SHORT    = 3'd3;
    localparam logic [2:0] FC_STUCK    = 3'd4;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_A    = 2'd1;
    localparam logic [1:0] PH_B    = 2'd2;

    // Lamp patterns packed as {Ago, Astop, Bgo, Bstop}
    localparam logic [3:0] LAMP_A_PH = 4'b1001;
    localparam logic [3:0] LAMP_B_PH = 4'b0110;
    localparam logic [3:0] LAMP_DARK = 4'b0000;

endpackage

// File: rtl/signal_monitor_if.sv
// rtl/signal_monitor_if.sv - lamp bundle between signal controller (master) and monitor (slave)
interface signal_monitor_if;
    logic Ago;
    logic Astop;
    logic Bgo;
    logic Bstop;

    modport master (output Ago, Astop, Bgo, Bstop);
    modport slave  (input  Ago, Astop, Bgo, Bstop);
endinterface

// File: rtl/signal_lamp_sampler.sv
// rtl/signal_lamp_sampler.sv - registers the lamp inputs and decodes them one-hot
module signal_lamp_sampler
    import signal_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    signal_monitor_if.slave        lamps,
    output logic                   a_ph,
    output logic                   b_ph,
    output logic                   dark,
    output logic                   illegal
);

    logic [3:0] sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample <= LAMP_DARK;
        end else begin
            sample <= {lamps.Ago, lamps.Astop, lamps.Bgo, lamps.Bstop};
        end
    end

    assign a_ph    = (sample == LAMP_A_PH);
    assign b_ph    = (sample == LAMP_B_PH);
    assign dark    = (sample == LAMP_DARK);
    assign illegal = ~(a_ph | b_ph | dark);

endmodule

// File: rtl/signal_monitor.sv
// rtl/signal_monitor.sv - lamp watchdog: conflict/dark/short/stuck detection with latched fault
module signal_monitor
    import signal_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int MIN_GREEN = 16,
    parameter int MAX_PHASE = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    signal_monitor_if.slave  lamps,
    input  logic             clear_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       phase,
    output logic [NBITS-1:0] dwell,
    output logic [NBITS-1:0] last_len,
    output logic [15:0]      handover_cnt,
    output logic             handover
);

    generate
        if (((64'(MAX_PHASE) >> NBITS) != 64'd0) || (MIN_GREEN > MAX_PHASE)) begin : g_bad_params
            $error("signal_monitor: need MAX_PHASE < 2**NBITS and MIN_GREEN <= MAX_PHASE");
        end
    endgenerate

    logic a_ph, b_ph, dark, illegal;

    signal_lamp_sampler u_sampler (
        .clk     (clk),
        .reset_n (reset_n),
        .lamps   (lamps),
        .a_ph    (a_ph),
        .b_ph    (b_ph),
        .dark    (dark),
        .illegal (illegal)
    );

    state_t     state;
    logic       run_same;
    logic       run_other;
    logic [2:0] det_code;

    assign run_same  = (state == ST_B_RUN) ? b_ph : a_ph;
    assign run_other = (state == ST_B_RUN) ? a_ph : b_ph;

    // One fault per sample, highest priority first
    always_comb begin
        det_code = FC_NONE;
        case (state)
            ST_IDLE: begin
                if (illegal) det_code = FC_CONFLICT;
            end
            ST_A_RUN, ST_B_RUN: begin
                if (illegal)
                    det_code = FC_CONFLICT;
                else if (dark)
                    det_code = FC_DARK;
                else if (run_other && (dwell < NBITS'(MIN_GREEN)))
                    det_code = FC_SHORT;
                else if (run_same && (dwell == NBITS'(MAX_PHASE)))
                    det_code = FC_STUCK;
            end
            default: det_code = FC_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
            phase        <= PH_NONE;
            dwell        <= '0;
            last_len     <= '0;
            handover_cnt <= '0;
            handover     <= 1'b0;
        end else begin
            handover <= 1'b0;
            if (state != ST_FAULT && det_code != FC_NONE) begin
                state      <= ST_FAULT;
                fault      <= 1'b1;
                fault_code <= det_code;
                phase      <= PH_NONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (a_ph) begin
                            state <= ST_A_RUN;
                            phase <= PH_A;
                            dwell <= NBITS'(1);
                        end else if (b_ph) begin
                            state <= ST_B_RUN;
                            phase <= PH_B;
                            dwell <= NBITS'(1);
                        end
                    end
                    ST_A_RUN, ST_B_RUN: begin
                        if (run_other) begin
                            state        <= (state == ST_A_RUN) ? ST_B_RUN : ST_A_RUN;
                            phase        <= (state == ST_A_RUN) ? PH_B : PH_A;
                            last_len     <= dwell;
                            dwell        <= NBITS'(1);
                            handover     <= 1'b1;
                            handover_cnt <= handover_cnt + 16'd1;
                        end else if (run_same) begin
                            dwell <= dwell + NBITS'(1);
                        end
                    end
                    ST_FAULT: begin
                        // Counters stay frozen; only an explicit clear leaves FAULT
                        if (clear_fault) begin
                            state      <= ST_IDLE;
                            fault      <= 1'b0;
                            fault_code <= FC_NONE;
                            dwell      <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/signal_monitor.md
Name: signal_monitor

Overview:
- Watchdog/receiver at the far end of the traffic-signal lamp interface; consumes Ago/Astop/Bgo/Bstop exactly as driven by the signal controller.
- Checks for conflicting lamp combinations, lamps going dark mid-operation, phases that end too early, and phases that run too long (stuck controller).
- Fault is latched until explicitly cleared.
- Also reports current phase, phase dwell time, the length of the last completed phase, and a handover count for debug/LED display.

Parameters:
- NBITS, 32, width of the dwell and length counters.
- MIN_GREEN, 16, minimum legal phase length in clk cycles; a shorter phase is a SHORT fault.
- MAX_PHASE, 256, maximum legal phase length in clk cycles; a longer phase is a STUCK fault.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Ago  input  1  approach A go lamp.
- Astop  input  1  approach A stop lamp.
- Bgo  input  1  approach B go lamp.
- Bstop  input  1  approach B stop lamp.
- clear_fault  input  1  synchronous request to leave FAULT; ignored in other states.
- fault  output  1  latched fault flag.
- fault_code  output  3  0 NONE, 1 CONFLICT, 2 DARK, 3 SHORT, 4 STUCK.
- phase  output  2  0 none, 1 A running, 2 B running.
- dwell  output  NBITS  sampled cycles spent in the current phase.
- last_len  output  NBITS  length of the most recently completed phase.
- handover_cnt  output  16  number of legal A<->B handovers; wraps at 16 bits.
- handover  output  1  one-cycle pulse on each legal handover.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; state IDLE; sample register cleared to DARK.
- Input stage: the four lamp inputs are registered every cycle (1-cycle sample latency). Each sample decodes as:
  - A_PH = Ago & ~Astop & ~Bgo & Bstop.
  - B_PH = ~Ago & Astop & Bgo & ~Bstop.
  - DARK = all four lamps 0.
  - ILLEGAL = any other combination.
- Total detection latency: a fault, phase or handover output changes on the 2nd rising edge after the lamp value is applied.
- State machine: IDLE, A_RUN, B_RUN, FAULT.
- IDLE:
  - DARK: stay.
  - A_PH: go to A_RUN, dwell=1, phase=1.
  - B_PH: go to B_RUN, dwell=1, phase=2.
  - ILLEGAL: go to FAULT, code CONFLICT.
- A_RUN (B_RUN symmetric, with A and B swapped):
  - A_PH: if dwell==MAX_PHASE, go to FAULT with code STUCK; otherwise dwell+1.
  - B_PH: if dwell<MIN_GREEN, go to FAULT with code SHORT. Otherwise:
    - last_len=dwell, dwell=1, phase=2, state B_RUN;
    - handover=1 for one cycle;
    - handover_cnt+1, wrapping 0xFFFF->0.
  - DARK: go to FAULT, code DARK.
  - ILLEGAL: go to FAULT, code CONFLICT.
- Fault priority for a single sample: CONFLICT > DARK > SHORT > STUCK. Only one fault is evaluated per sample.
- FAULT:
  - fault=1 and fault_code are held; phase=0.
  - dwell, last_len and handover_cnt are frozen.
  - New faults do not overwrite fault_code.
- clear_fault in FAULT: next edge goes to IDLE with fault=0, fault_code=0, dwell=0. last_len and handover_cnt are retained.
- If the bad condition persists after a clear, it is re-detected normally from IDLE. DARK in IDLE is legal, so DARK never re-faults from IDLE.
- clear_fault asserted together with a new fault condition in a RUN state: the fault wins and clear_fault is ignored.
- Asynchronous reset mid-phase or while in FAULT: immediate return to reset values; no fault survives reset.
- Counters: dwell cannot overflow because MAX_PHASE must be < 2^NBITS; this is enforced with an elaboration-time check. MIN_GREEN must be <= MAX_PHASE.

Decomposition:
- Shared package signal_pkg holds:
  - state encodings IDLE/A_RUN/B_RUN/FAULT;
  - fault_code constants NONE/CONFLICT/DARK/SHORT/STUCK;
  - phase encodings;
  - lamp-pattern constants A_PH/B_PH/DARK.
- The signal controller should import the same lamp-pattern constants from signal_pkg.
- One sub-module: signal_lamp_sampler. It contains the reset_n-cleared lamp register plus decode, and outputs one-hot a_ph/b_ph/dark/illegal.

Test Plan:
- Normal run: A_PH for 40 cycles, then B_PH for 40, then A_PH. Expect handover pulses 2 cycles after each switch, last_len=40, handover_cnt=2, fault=0 throughout.
- Conflict: in A_RUN at dwell=10, drive Ago=1 and Bgo=1 for one cycle. Expect fault=1 and fault_code=1 two edges later, phase=0, dwell frozen at 11.
- Short phase: A_PH for 20 cycles, then B_PH for 5, then A_PH. Expect fault_code=3 when the A_PH sample arrives with dwell=5, and handover_cnt=1.
- Stuck: hold A_PH for 300 cycles. Expect fault_code=4 asserted when sample 257 is seen, and dwell=256 frozen.
- Dark, then clear: in B_RUN drive all lamps 0. Expect fault_code=2. Pulse clear_fault with lamps still dark: expect IDLE, fault=0, with no re-fault. Then drive A_PH and expect phase=1.
- Async reset: assert reset_n=0 mid-edge during FAULT. Expect all outputs 0 immediately, without waiting for a clock edge. After release, A_PH then B_PH (each >=16 cycles) must count from handover_cnt=0.
